// File: rtl/spectro_pkg.sv
// Shared constants and FSM state encoding for the spectrogram frame sequencer.
package spectro_pkg;

  localparam int N_CH     = 16;
  localparam int WORD_W   = 12;
  localparam int PERIOD_W = 16;
  localparam int SEL_W    = 4;
  localparam int BIT_W    = 4;
  localparam int FCNT_W   = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_CLR   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_WAIT  = ST_WAIT,
    S_LOAD  = ST_LOAD,
    S_SHIFT = ST_SHIFT,
    S_CLR   = ST_CLR
  } state_e;

endpackage

// File: rtl/spectro_frame_sequencer_ch_next_sel.sv
// Priority encoder picking the next enabled channel: the lowest set bit above
// cur_idx, or the lowest set bit overall when first is high.
module ch_next_sel
  import spectro_pkg::*;
(
  input  logic [N_CH-1:0]  mask_q,
  input  logic [SEL_W-1:0] cur_idx,
  input  logic             first,
  output logic [SEL_W-1:0] next_idx,
  output logic             next_vld
);

  // Scan from the top down so the last qualifying hit is the lowest index.
  always_comb begin
    next_idx = '0;
    next_vld = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (first || (i > int'(cur_idx)))) begin
        next_idx = SEL_W'(i);
        next_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spectro_frame_sequencer.sv
// Frame-level readout scheduler: integration timer, per-channel wait/load/shift
// sequencing over the latched channel mask, frame-end accumulator clear and
// sticky overrun reporting.
module spectro_frame_sequencer
  import spectro_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [N_CH-1:0]     ch_mask,
  input  logic                out_ready,
  input  logic                ovr_clr,
  output logic [SEL_W-1:0]    selection,
  output logic                sl,
  output logic                shift_en,
  output logic                acc_clr,
  output logic                frame_start,
  output logic                frame_done,
  output logic                busy,
  output logic                overrun,
  output logic [FCNT_W-1:0]   frame_cnt
);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SEL_W-1:0]    ch_idx_q, ch_idx_d;
  logic [N_CH-1:0]     mask_q, mask_d;
  logic                frame_start_q, frame_start_d;
  logic                overrun_q, overrun_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic                timer_run;
  logic                tick;
  logic                sel_first;
  logic [N_CH-1:0]     sel_mask;
  logic [SEL_W-1:0]    nxt_idx;
  logic                nxt_vld;

  assign timer_run = enable && (period != '0);
  assign tick      = timer_run && (timer_q == period - 1'b1);

  // In IDLE the encoder looks at the live mask to find the first channel of the
  // frame being accepted; afterwards only the latched mask is consulted.
  assign sel_first = (state_q == S_IDLE);
  assign sel_mask  = sel_first ? ch_mask : mask_q;

  ch_next_sel u_next_sel (
    .mask_q   (sel_mask),
    .cur_idx  (ch_idx_q),
    .first    (sel_first),
    .next_idx (nxt_idx),
    .next_vld (nxt_vld)
  );

  // Integration timer: counts 0..period-1, and any value at or past the wrap
  // point (e.g. after period was lowered) falls back to 0 without a tick.
  always_comb begin
    timer_d = '0;
    if (timer_run && (timer_q < period - 1'b1)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Sticky overrun: a tick while busy drops that frame; setting beats clearing.
  always_comb begin
    overrun_d = overrun_q;
    if (tick && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  // Frame FSM next-state logic with channel index and bit counter updates.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    ch_idx_d      = ch_idx_q;
    mask_d        = mask_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          mask_d        = ch_mask;
          frame_start_d = 1'b1;
          if (nxt_vld) begin
            ch_idx_d = nxt_idx;
            state_d  = S_WAIT;
          end else begin
            state_d = S_CLR;
          end
        end
      end
      S_WAIT: begin
        if (out_ready) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        bit_cnt_d = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
          if (nxt_vld) begin
            ch_idx_d = nxt_idx;
            state_d  = S_WAIT;
          end else begin
            state_d = S_CLR;
          end
        end
      end
      S_CLR: begin
        frame_cnt_d = frame_cnt_q + 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register for timer, FSM and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      bit_cnt_q     <= '0;
      ch_idx_q      <= '0;
      mask_q        <= '0;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      bit_cnt_q     <= bit_cnt_d;
      ch_idx_q      <= ch_idx_d;
      mask_q        <= mask_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Moore output decode from the current state.
  always_comb begin
    selection = '0;
    sl        = 1'b0;
    shift_en  = 1'b0;
    acc_clr   = 1'b0;
    case (state_q)
      S_WAIT:  selection = ch_idx_q;
      S_LOAD: begin
        selection = ch_idx_q;
        sl        = 1'b1;
      end
      S_SHIFT: begin
        selection = ch_idx_q;
        shift_en  = 1'b1;
      end
      S_CLR:   acc_clr = 1'b1;
      default: selection = '0;
    endcase
  end

  assign frame_done  = acc_clr;
  assign busy        = (state_q != S_IDLE);
  assign frame_start = frame_start_q;
  assign overrun     = overrun_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
